control_sequencer: RTL and testbench

SAP-1 controller-sequencer: consumes the 6-bit one-hot T-state from the ring counter and emits the 12-bit control word that drives PC, MAR, RAM, IR, accumulator, ALU, B and output registers. It holds a private copy of the current opcode, a sticky halt latch, a sticky state-fault flag and a retired-instruction counter. It sits between the ring counter/instruction register and every other datapath register.

---
 rtl/control_sequencer.sv | 51 +++++
 tb/tb_control_sequencer.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// control_sequencer: SAP-1 controller-sequencer that maps the one-hot T-state and latched opcode to the control word.
module control_sequencer (
   input  logic        CLK,
   input  logic        CLR,
   input  logic [5:0]  state,
   input  logic [3:0]  ir_hi,
   output logic [11:0] con,
   output logic        HLT,
   output logic        FAULT,
   output logic [7:0]  instr_count
);
   localparam logic [11:0] NOP = 12'h3E3;
   logic [3:0] op_q;
   logic       hlt_q, fault_q;
   logic [7:0] cnt_q, cnt_d;
   logic       legal, run, is_lda, is_add, is_sub, is_out;
   assign legal  = ~|(state & (state - 6'd1));
   assign run    = ~hlt_q & ~fault_q;
   assign is_lda = op_q == 4'b0000;
   assign is_add = op_q == 4'b0001;
   assign is_sub = op_q == 4'b0010;
   assign is_out = op_q == 4'b1110;
   assign cnt_d  = cnt_q + 8'd1;
   assign HLT         = hlt_q;
   assign FAULT       = fault_q;
   assign instr_count = cnt_q;
   // CLR also forces NOP so the word is safe while the ring counter is still being cleared
   always_comb begin
      con = NOP;
      if (!CLR && run && legal)
         con = state[0] ? 12'h5E3 :
               state[1] ? 12'hBE3 :
               state[2] ? 12'h263 :
               state[3] ? ((is_lda | is_add | is_sub) ? 12'h1A3 : is_out ? 12'h3F2 : NOP) :
               state[4] ? (is_lda ? 12'h2C3 : (is_add | is_sub) ? 12'h2E1 : NOP) :
               state[5] ? (is_add ? 12'h3C7 : is_sub ? 12'h3CF : NOP) : NOP;
   end
   always_ff @(posedge CLK or posedge CLR) begin
      if (CLR) begin
         op_q    <= 4'b0000;
         hlt_q   <= 1'b0;
         fault_q <= 1'b0;
         cnt_q   <= 8'h00;
      end else begin
         if (!legal) fault_q <= 1'b1;
         else if (state == 6'b001000 && op_q == 4'b1111 && !fault_q) hlt_q <= 1'b1;
         if (state == 6'b000100 && run) op_q <= ir_hi;
         if (state == 6'b100000 && run) cnt_q <= cnt_d;
      end
   end
endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: scoreboard bench driving T-states on negedge and checking con, HLT, FAULT and instr_count.
module tb_control_sequencer;
   logic        CLK = 1'b0;
   logic        CLR;
   logic [5:0]  state;
   logic [3:0]  ir_hi;
   logic [11:0] con;
   logic        HLT, FAULT;
   logic [7:0]  instr_count;
   int checks = 0;
   int failures = 0;
   int exp_cnt = 0;
   logic [11:0] exp_q[$];
   localparam logic [11:0] NOP = 12'h3E3;

   control_sequencer dut (
      .CLK(CLK), .CLR(CLR), .state(state), .ir_hi(ir_hi),
      .con(con), .HLT(HLT), .FAULT(FAULT), .instr_count(instr_count)
   );

   always #5 CLK = ~CLK;

   initial begin
      #900000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   task automatic tick(input logic [5:0] s, input logic [3:0] ir, input logic [11:0] e);
      logic [11:0] x;
      @(negedge CLK);
      state = s;
      ir_hi = ir;
      exp_q.push_back(e);
      #2;
      x = exp_q.pop_front();
      checks++;
      if (con !== x) begin
         failures++;
         $display("FAIL con state=%b got=%h exp=%h t=%0t", s, con, x, $time);
      end
      @(posedge CLK);
      #1;
   endtask

   task automatic chk_regs(input string nm, input logic h, input logic f);
      checks++;
      if (HLT !== h || FAULT !== f || instr_count !== 8'(exp_cnt)) begin
         failures++;
         $display("FAIL %s hlt=%b/%b fault=%b/%b cnt=%h/%h", nm, HLT, h, FAULT, f, instr_count, 8'(exp_cnt));
      end
   endtask

   task automatic run_instr(input logic [3:0] op, input logic [11:0] e4, input logic [11:0] e5, input logic [11:0] e6);
      tick(6'b000001, 4'hA, 12'h5E3);
      tick(6'b000010, 4'hA, 12'hBE3);
      tick(6'b000100, op,   12'h263);
      tick(6'b001000, 4'hA, e4);
      tick(6'b010000, 4'hA, e5);
      tick(6'b100000, 4'hA, e6);
      exp_cnt = (exp_cnt + 1) % 256;
   endtask

   task automatic do_reset;
      @(negedge CLK);
      CLR = 1'b1;
      state = 6'b000000;
      #2;
      exp_cnt = 0;
      @(negedge CLK);
      #2;
      CLR = 1'b0;
   endtask

   task automatic test_reset;
      CLR = 1'b1;
      state = 6'b000000;
      ir_hi = 4'h0;
      #3;
      checks++;
      if (con !== NOP) begin failures++; $display("FAIL reset_con got=%h exp=%h", con, NOP); end
      chk_regs("reset_regs", 1'b0, 1'b0);
      @(negedge CLK);
      #2;
      CLR = 1'b0;
      tick(6'b000000, 4'h0, NOP);
      chk_regs("idle_regs", 1'b0, 1'b0);
   endtask

   task automatic test_lda;
      run_instr(4'b0000, 12'h1A3, 12'h2C3, NOP);
      chk_regs("lda_cnt", 1'b0, 1'b0);
   endtask

   task automatic test_back_to_back;
      run_instr(4'b0001, 12'h1A3, 12'h2E1, 12'h3C7);
      run_instr(4'b0010, 12'h1A3, 12'h2E1, 12'h3CF);
      chk_regs("addsub_cnt", 1'b0, 1'b0);
   endtask

   task automatic test_out_hlt;
      run_instr(4'b1110, 12'h3F2, NOP, NOP);
      chk_regs("out_cnt", 1'b0, 1'b0);
      tick(6'b000001, 4'hA, 12'h5E3);
      tick(6'b000010, 4'hA, 12'hBE3);
      tick(6'b000100, 4'b1111, 12'h263);
      tick(6'b001000, 4'hA, NOP);
      chk_regs("hlt_set", 1'b1, 1'b0);
      checks++;
      if (con !== NOP) begin failures++; $display("FAIL hlt_t4_con got=%h exp=%h", con, NOP); end
      tick(6'b010000, 4'hA, NOP);
      tick(6'b100000, 4'hA, NOP);
      tick(6'b000001, 4'hA, NOP);
      tick(6'b000010, 4'hA, NOP);
      tick(6'b000100, 4'b0000, NOP);
      tick(6'b001000, 4'hA, NOP);
      tick(6'b010000, 4'hA, NOP);
      tick(6'b100000, 4'hA, NOP);
      chk_regs("hlt_hold", 1'b1, 1'b0);
   endtask

   task automatic test_fault;
      do_reset();
      chk_regs("fault_pre", 1'b0, 1'b0);
      tick(6'b000011, 4'hA, NOP);
      chk_regs("fault_set", 1'b0, 1'b1);
      tick(6'b000001, 4'hA, NOP);
      tick(6'b000010, 4'hA, NOP);
      tick(6'b000100, 4'b0001, NOP);
      tick(6'b001000, 4'hA, NOP);
      tick(6'b010000, 4'hA, NOP);
      tick(6'b100000, 4'hA, NOP);
      chk_regs("fault_hold", 1'b0, 1'b1);
   endtask

   task automatic test_wrap;
      do_reset();
      for (int i = 0; i < 255; i++) run_instr(4'b0101, NOP, NOP, NOP);
      chk_regs("cnt_ff", 1'b0, 1'b0);
      run_instr(4'b0101, NOP, NOP, NOP);
      chk_regs("cnt_wrap", 1'b0, 1'b0);
   endtask

   task automatic test_clr_mid;
      run_instr(4'b0000, 12'h1A3, 12'h2C3, NOP);
      tick(6'b000001, 4'hA, 12'h5E3);
      tick(6'b000010, 4'hA, 12'hBE3);
      tick(6'b000100, 4'b0001, 12'h263);
      tick(6'b001000, 4'hA, 12'h1A3);
      @(negedge CLK);
      state = 6'b010000;
      #2;
      checks++;
      if (con !== 12'h2E1) begin failures++; $display("FAIL add_t5 got=%h exp=%h", con, 12'h2E1); end
      CLR = 1'b1;
      exp_cnt = 0;
      #1;
      checks++;
      if (con !== NOP) begin failures++; $display("FAIL clr_con got=%h exp=%h", con, NOP); end
      chk_regs("clr_regs", 1'b0, 1'b0);
      @(negedge CLK);
      #2;
      CLR = 1'b0;
      tick(6'b010000, 4'hA, 12'h2C3);
      run_instr(4'b0010, 12'h1A3, 12'h2E1, 12'h3CF);
      chk_regs("clr_sub", 1'b0, 1'b0);
   endtask

   initial begin
      test_reset();
      test_lda();
      test_back_to_back();
      test_out_hlt();
      test_fault();
      test_wrap();
      test_clr_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
